// File: rtl/spi_master_ctrl_if.sv
// Command/completion channel between a requester and spi_master_ctrl.
// The requester uses the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_wr;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_wdata;
  logic              o_done;
  logic [DATA_W-1:0] o_rdata;
  logic              o_err;

  modport master (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wdata,
    input  o_cmd_ready, o_done, o_rdata, o_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wdata,
    output o_cmd_ready, o_done, o_rdata, o_err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Command-driven SPI master: serialises op/addr/wdata LSB first, then waits for slave strobes.
// Optional wait-state timeout is compiled in with SPI_MASTER_TIMEOUT_EN.
module spi_master_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
`ifdef SPI_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_ctrl_if.slave    cmd,
  output logic                o_cs,
  output logic                o_mosi,
  input  logic                i_miso,
  input  logic                i_ready,
  input  logic                i_op_done
);

  localparam int SH_W  = ADDR_W + DATA_W;
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    OP,
    ADDR,
    WDATA,
    WAIT_RDY,
    RX,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;

`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  assign accept          = cmd.i_cmd_valid && (state_q == IDLE);
  assign cmd.o_cmd_ready = (state_q == IDLE);
  assign cmd.o_done      = done_q;
  assign cmd.o_rdata     = rdata_q;
  assign o_cs            = cs_q;
  assign o_mosi          = mosi_q;
`ifdef SPI_MASTER_TIMEOUT_EN
  assign cmd.o_err       = err_q;
`else
  assign cmd.o_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    sh_d    = sh_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
`ifdef SPI_MASTER_TIMEOUT_EN
    err_d   = 1'b0;
    tmo_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d   = cmd.i_cmd_wr;
          sh_d   = {cmd.i_cmd_wdata, cmd.i_cmd_addr};
          cs_d   = 1'b0;
          mosi_d = cmd.i_cmd_wr;
          cnt_d  = '0;
          state_d = OP;
          if (!cmd.i_cmd_wr) rdata_d = '0;
        end
      end
      // Op bit is held for a second cycle so the slave can leave idle first.
      OP: state_d = ADDR;
      ADDR: begin
        if (cnt_q == ADDR_END) begin
          if (wr_q) begin
            mosi_d  = sh_q[0];
            sh_d    = sh_q >> 1;
            cnt_d   = CNT_ONE;
            state_d = WDATA;
          end else begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = WAIT_RDY;
          end
        end else begin
          mosi_d = sh_q[0];
          sh_d   = sh_q >> 1;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      WDATA: begin
        if (cnt_q == DATA_END) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = WAIT_DONE;
        end else begin
          mosi_d = sh_q[0];
          sh_d   = sh_q >> 1;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      WAIT_RDY: begin
        if (i_ready) begin
          cnt_d   = '0;
          state_d = RX;
        end
`ifdef SPI_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
`endif
      end
      // LSB arrives first, so shift in from the top.
      RX: begin
        rdata_d = {i_miso, rdata_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == RX_LAST) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_op_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef SPI_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
`ifdef SPI_MASTER_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
`ifdef SPI_MASTER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // Shift register is pure datapath: always loaded on accept before use.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI memory slave.
// Define SPI_MASTER_TIMEOUT_EN to include the timeout scenario.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_cs, o_mosi;
  logic i_miso = 1'b0;
  logic i_ready = 1'b0;
  logic i_op_done = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  spi_master_ctrl_if #(.ADDR_W(8), .DATA_W(8)) cif ();

  spi_master_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .o_cs      (o_cs),
    .o_mosi    (o_mosi),
    .i_miso    (i_miso),
    .i_ready   (i_ready),
    .i_op_done (i_op_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural slave: samples o_cs/o_mosi and drives strobes on the falling edge.
  typedef enum {S_IDLE, S_SHIFT, S_DELAY, S_RDY, S_TX, S_DONE} sst_t;
  sst_t        sst = S_IDLE;
  logic [17:0] sbits = '0;
  logic [4:0]  sidx = '0;
  logic        s_wr = 1'b0;
  logic [7:0]  s_addr = '0;
  logic [3:0]  tx_cnt = '0;
  logic [7:0]  mem [0:255];
  bit          mute = 1'b0;
  bit          spurious = 1'b0;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      sst       <= S_IDLE;
      sidx      <= '0;
      i_ready   <= 1'b0;
      i_op_done <= 1'b0;
      i_miso    <= 1'b0;
    end else begin
      case (sst)
        S_IDLE: begin
          i_op_done <= 1'b0;
          if (!o_cs) begin
            sbits[0]  <= o_mosi;
            sidx      <= 5'd1;
            i_ready   <= spurious;
            i_op_done <= spurious;
            sst       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!o_cs) begin
            if (sidx < 5'd18) sbits[sidx] <= o_mosi;
            sidx      <= sidx + 5'd1;
            i_ready   <= spurious;
            i_op_done <= spurious;
          end else begin
            i_ready   <= 1'b0;
            i_op_done <= 1'b0;
            s_wr      <= sbits[1];
            s_addr    <= sbits[9:2];
            if (sbits[1] && sidx == 5'd18) mem[sbits[9:2]] <= sbits[17:10];
            sst       <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (s_wr) begin
            i_op_done <= 1'b1;
            sst       <= S_IDLE;
          end else if (mute) begin
            sst <= S_IDLE;
          end else begin
            i_ready <= 1'b1;
            sst     <= S_RDY;
          end
        end
        S_RDY: begin
          i_ready <= 1'b0;
          i_miso  <= mem[s_addr][0];
          tx_cnt  <= 4'd1;
          sst     <= S_TX;
        end
        S_TX: begin
          i_miso <= mem[s_addr][tx_cnt[2:0]];
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'd7) sst <= S_DONE;
        end
        S_DONE: begin
          i_miso    <= 1'b0;
          i_op_done <= 1'b1;
          sst       <= S_IDLE;
        end
        default: sst <= S_IDLE;
      endcase
    end
  end

  initial begin
    cif.i_cmd_valid = 1'b0;
    cif.i_cmd_wr    = 1'b0;
    cif.i_cmd_addr  = '0;
    cif.i_cmd_wdata = '0;
  end

  // Issue one command at the current falling edge; trace bit n is the value after edge En.
  task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input bit hold,
                         output logic [63:0] cs_tr, output logic [63:0] mosi_tr,
                         output logic [63:0] rdy_tr, output int done_at,
                         output logic err_o, output logic [7:0] rd_o, output logic [7:0] rd0);
    cs_tr = '1; mosi_tr = '0; rdy_tr = '0;
    done_at = -1; err_o = 1'b0; rd_o = '0; rd0 = '0;
    cif.i_cmd_valid = 1'b1;
    cif.i_cmd_wr    = wr;
    cif.i_cmd_addr  = addr;
    cif.i_cmd_wdata = wdata;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (n == 0) begin
        rd0 = cif.o_rdata;
        if (hold) begin
          cif.i_cmd_wr    = ~wr;
          cif.i_cmd_addr  = ~addr;
          cif.i_cmd_wdata = ~wdata;
        end else begin
          cif.i_cmd_valid = 1'b0;
        end
      end
      if (n < 64) begin
        cs_tr[n]   = o_cs;
        mosi_tr[n] = o_mosi;
        rdy_tr[n]  = cif.o_cmd_ready;
      end
      if (cif.o_done) begin
        done_at = n;
        err_o   = cif.o_err;
        rd_o    = cif.o_rdata;
        break;
      end
    end
  endtask

  logic [63:0] cs_tr, mosi_tr, rdy_tr;
  int          done_at;
  logic        err_o;
  logic [7:0]  rd_o, rd0;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (o_cs !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b want 1", o_cs); end
    n_vec++; if (o_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", o_mosi); end
    n_vec++; if (cif.o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", cif.o_done); end
    n_vec++; if (cif.o_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", cif.o_err); end
    n_vec++; if (cif.o_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", cif.o_rdata); end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (cif.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cif.o_cmd_ready); end
    n_vec++; if (o_cs !== 1'b1) begin n_err++; $display("FAIL post_reset_cs: got %b want 1", o_cs); end
  endtask

  task automatic test_write();
    run_cmd(1'b1, 8'h03, 8'hA5, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (cs_tr[18:0] !== 19'h40000) begin n_err++; $display("FAIL wr_cs_trace: got %h want 40000", cs_tr[18:0]); end
    n_vec++; if (mosi_tr[18:0] !== 19'h2940F) begin n_err++; $display("FAIL wr_mosi_trace: got %h want 2940f", mosi_tr[18:0]); end
    n_vec++; if (done_at !== 20) begin n_err++; $display("FAIL wr_latency: got %0d want 20", done_at); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL wr_err: got %b want 0", err_o); end
    n_vec++; if (rdy_tr[0] !== 1'b0) begin n_err++; $display("FAIL wr_ready_busy: got %b want 0", rdy_tr[0]); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    run_cmd(1'b0, 8'h03, 8'h00, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (cs_tr[10:0] !== 11'h400) begin n_err++; $display("FAIL rd_cs_trace: got %h want 400", cs_tr[10:0]); end
    n_vec++; if (mosi_tr[10:0] !== 11'h00C) begin n_err++; $display("FAIL rd_mosi_trace: got %h want 00c", mosi_tr[10:0]); end
    n_vec++; if (done_at !== 21) begin n_err++; $display("FAIL rd_latency: got %0d want 21", done_at); end
    n_vec++; if (rd_o !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", rd_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", err_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b1, 8'h1F, 8'h3C, 1'b1, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (mosi_tr[18:0] !== 19'h0F07F) begin n_err++; $display("FAIL b2b_wr_mosi: got %h want 0f07f", mosi_tr[18:0]); end
    n_vec++; if (cs_tr[18:0] !== 19'h40000) begin n_err++; $display("FAIL b2b_wr_cs: got %h want 40000", cs_tr[18:0]); end
    n_vec++; if (done_at !== 20) begin n_err++; $display("FAIL b2b_wr_latency: got %0d want 20", done_at); end
    n_vec++; if (rdy_tr[5] !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", rdy_tr[5]); end
    n_vec++; if (rdy_tr[20] !== 1'b1) begin n_err++; $display("FAIL done_cycle_ready: got %b want 1", rdy_tr[20]); end
    n_vec++; if (rd_o !== 8'hA5) begin n_err++; $display("FAIL wr_keeps_rdata: got %h want a5", rd_o); end
    run_cmd(1'b0, 8'h1F, 8'h00, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (rd0 !== 8'h00) begin n_err++; $display("FAIL rd_accept_clears: got %h want 00", rd0); end
    n_vec++; if (mosi_tr[10:0] !== 11'h07C) begin n_err++; $display("FAIL b2b_rd_mosi: got %h want 07c", mosi_tr[10:0]); end
    n_vec++; if (done_at !== 21) begin n_err++; $display("FAIL b2b_rd_latency: got %0d want 21", done_at); end
    n_vec++; if (rd_o !== 8'h3C) begin n_err++; $display("FAIL b2b_rd_data: got %h want 3c", rd_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int spurious_done;
    cif.i_cmd_valid = 1'b1;
    cif.i_cmd_wr    = 1'b1;
    cif.i_cmd_addr  = 8'h55;
    cif.i_cmd_wdata = 8'h66;
    @(negedge clk);
    cif.i_cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (o_cs !== 1'b1) begin n_err++; $display("FAIL midrst_cs: got %b want 1", o_cs); end
    n_vec++; if (o_mosi !== 1'b0) begin n_err++; $display("FAIL midrst_mosi: got %b want 0", o_mosi); end
    n_vec++; if (cif.o_rdata !== 8'h00) begin n_err++; $display("FAIL midrst_rdata: got %h want 00", cif.o_rdata); end
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    spurious_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cif.o_done) spurious_done++;
    end
    n_vec++; if (spurious_done !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", spurious_done); end
    spurious = 1'b1;
    run_cmd(1'b1, 8'h55, 8'h66, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (mosi_tr[18:0] !== 19'h19957) begin n_err++; $display("FAIL recov_wr_mosi: got %h want 19957", mosi_tr[18:0]); end
    n_vec++; if (done_at !== 20) begin n_err++; $display("FAIL recov_wr_latency: got %0d want 20", done_at); end
    repeat (2) @(negedge clk);
    run_cmd(1'b0, 8'h55, 8'h00, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (done_at !== 21) begin n_err++; $display("FAIL recov_rd_latency: got %0d want 21", done_at); end
    n_vec++; if (rd_o !== 8'h66) begin n_err++; $display("FAIL recov_rd_data: got %h want 66", rd_o); end
    spurious = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef SPI_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    mute = 1'b1;
    run_cmd(1'b0, 8'h03, 8'h00, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (done_at !== 74) begin n_err++; $display("FAIL tmo_latency: got %0d want 74", done_at); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", err_o); end
    n_vec++; if (rd_o !== 8'h00) begin n_err++; $display("FAIL tmo_rdata: got %h want 00", rd_o); end
    n_vec++; if (o_cs !== 1'b1) begin n_err++; $display("FAIL tmo_cs: got %b want 1", o_cs); end
    mute = 1'b0;
    repeat (2) @(negedge clk);
    run_cmd(1'b0, 8'h03, 8'h00, 1'b0, cs_tr, mosi_tr, rdy_tr, done_at, err_o, rd_o, rd0);
    n_vec++; if (rd_o !== 8'hA5) begin n_err++; $display("FAIL tmo_recov_data: got %h want a5", rd_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL tmo_recov_err: got %b want 0", err_o); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SPI_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
